// File: rtl/vend_pkg.sv
// Coin codes and acceptor state encoding shared by coin_acceptor and vending_machine.
package vend_pkg;

    localparam logic [1:0] COIN_NONE = 2'b00;
    localparam logic [1:0] COIN_5    = 2'b01;
    localparam logic [1:0] COIN_10   = 2'b10;
    localparam logic [1:0] COIN_BOTH = 2'b11;

    localparam logic [7:0] COUNT_MAX = 8'hFF;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        DEBOUNCE     = 2'd1,
        WAIT_RELEASE = 2'd2
    } acc_state_t;

    // Only a single-slot reading is a real coin; both slots at once is a jam.
    function automatic logic is_single_coin(input logic [1:0] code);
        return (code == COIN_5) || (code == COIN_10);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for one asynchronous level input, resets to 0.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/coin_acceptor.sv
// Debounces the two coin slot detectors and hands one coin code per inserted coin
// to the vending machine, or rejects jams and coins arriving while disabled.
//
// state        | meaning
// IDLE         | slots empty, waiting for a nonzero synchronized reading
// DEBOUNCE     | reading nonzero, counting consecutive identical samples
// WAIT_RELEASE | coin qualified, waiting for a stable empty reading
module coin_acceptor
    import vend_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sense_5,
    input  logic       sense_10,
    input  logic       accept_en,
    output logic [1:0] coin,
    output logic       coin_reject,
    output logic       busy,
    output logic [7:0] coin_count
);

    // Timer counts down from the load value; zero is the terminal count.
    localparam logic [3:0] CNT_LOAD = 4'(DEBOUNCE_CYCLES - 1);

    logic       sync_5;
    logic       sync_10;
    logic [1:0] s;

    acc_state_t state;
    acc_state_t state_nxt;
    logic [3:0] cnt;
    logic [3:0] cnt_nxt;
    logic [1:0] cap;
    logic [1:0] cap_nxt;
    logic       qualify;
    logic       accept;
    logic       reject;

    sync_2ff u_sync_5 (
        .clk (clk),
        .rst (rst),
        .d   (sense_5),
        .q   (sync_5)
    );

    sync_2ff u_sync_10 (
        .clk (clk),
        .rst (rst),
        .d   (sense_10),
        .q   (sync_10)
    );

    assign s = {sync_10, sync_5};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= 4'd0;
            cap   <= COIN_NONE;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            cap   <= cap_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        cap_nxt   = cap;
        qualify   = 1'b0;
        case (state)
            IDLE: begin
                if (s != COIN_NONE) begin
                    state_nxt = DEBOUNCE;
                    cap_nxt   = s;
                    cnt_nxt   = CNT_LOAD;
                end
            end
            DEBOUNCE: begin
                if (s == COIN_NONE) begin
                    state_nxt = IDLE;
                end else if (s != cap) begin
                    cap_nxt = s;
                    cnt_nxt = CNT_LOAD;
                end else if (cnt == 4'd0) begin
                    qualify   = 1'b1;
                    state_nxt = WAIT_RELEASE;
                    cnt_nxt   = CNT_LOAD;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            WAIT_RELEASE: begin
                // A coin still in the slot restarts the release timer.
                if (s != COIN_NONE) begin
                    cnt_nxt = CNT_LOAD;
                end else if (cnt == 4'd0) begin
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = 4'd0;
                cap_nxt   = COIN_NONE;
            end
        endcase
    end

    assign accept = qualify && accept_en && is_single_coin(cap);
    assign reject = qualify && !accept;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            coin        <= COIN_NONE;
            coin_reject <= 1'b0;
            busy        <= 1'b0;
            coin_count  <= 8'd0;
        end else begin
            coin        <= accept ? cap : COIN_NONE;
            coin_reject <= reject;
            busy        <= (state_nxt != IDLE);
            if (accept && (coin_count != COUNT_MAX)) begin
                coin_count <= coin_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_coin_acceptor.sv
// Randomized and directed bench for coin_acceptor against a run-length reference model.
module tb_coin_acceptor;
    import vend_pkg::*;

    localparam int D = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       sense_5;
    logic       sense_10;
    logic       accept_en;
    logic [1:0] coin;
    logic       coin_reject;
    logic       busy;
    logic [7:0] coin_count;

    int n_tests = 0;
    int n_fail = 0;
    int cyc = 0;
    int last_coin_cyc = -1;
    int coins_seen = 0;
    int rejects_seen = 0;
    logic [1:0] last_coin_val = 2'b00;

    // Reference model: slot samples delayed two clocks, then judged by run lengths.
    logic [1:0] pipe1, pipe2, m_prev;
    int         m_run, m_zrun, m_count;
    bit         m_holding;
    logic [1:0] m_coin;
    bit         m_rej;

    coin_acceptor #(.DEBOUNCE_CYCLES(D)) dut (
        .clk         (clk),
        .rst         (rst),
        .sense_5     (sense_5),
        .sense_10    (sense_10),
        .accept_en   (accept_en),
        .coin        (coin),
        .coin_reject (coin_reject),
        .busy        (busy),
        .coin_count  (coin_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_reset();
        pipe1     = 2'b00;
        pipe2     = 2'b00;
        m_prev    = 2'b00;
        m_run     = 0;
        m_zrun    = 0;
        m_holding = 1'b0;
        m_coin    = 2'b00;
        m_rej     = 1'b0;
        m_count   = 0;
    endtask

    task automatic model_edge();
        logic [1:0] s;
        s      = pipe2;
        pipe2  = pipe1;
        pipe1  = {sense_10, sense_5};
        m_coin = 2'b00;
        m_rej  = 1'b0;
        if (!m_holding) begin
            if (s == 2'b00) m_run = 0;
            else if (m_run > 0 && s == m_prev) m_run++;
            else m_run = 1;
            m_prev = s;
            if (m_run == D + 1) begin
                if (s != 2'b11 && accept_en) begin
                    m_coin = s;
                    if (m_count < 255) m_count++;
                end else begin
                    m_rej = 1'b1;
                end
                m_holding = 1'b1;
                m_zrun    = 0;
                m_run     = 0;
            end
        end else begin
            if (s == 2'b00) m_zrun++;
            else m_zrun = 0;
            if (m_zrun == D) m_holding = 1'b0;
        end
    endtask

    task automatic step(input logic [1:0] code, input logic en);
        @(negedge clk);
        check("coin", coin, m_coin);
        check("coin_reject", coin_reject, m_rej);
        check("busy", busy, m_holding || (m_run > 0));
        check("coin_count", coin_count, m_count);
        check("coin_and_reject", (coin != 2'b00) && coin_reject, 0);
        if (coin != 2'b00) begin
            coins_seen++;
            last_coin_cyc = cyc;
            last_coin_val = coin;
        end
        if (coin_reject) rejects_seen++;
        sense_5   = code[0];
        sense_10  = code[1];
        accept_en = en;
        @(posedge clk);
        if (!rst) model_reset();
        else model_edge();
        cyc++;
    endtask

    task automatic hold(input logic [1:0] code, input logic en, input int n);
        for (int i = 0; i < n; i++) step(code, en);
    endtask

    initial begin
        int start, c0, r0, k0;
        logic [1:0] bounce [5];

        rst       = 1'b0;
        sense_5   = 1'b0;
        sense_10  = 1'b0;
        accept_en = 1'b1;
        model_reset();
        #12;
        check("rst_coin", coin, 0);
        check("rst_reject", coin_reject, 0);
        check("rst_busy", busy, 0);
        check("rst_count", coin_count, 0);
        @(negedge clk);
        rst = 1'b1;
        hold(2'b00, 1'b1, 3);

        // Clean 5-rupee coin and its latency.
        start = cyc;
        c0 = coins_seen;
        hold(2'b01, 1'b1, 20);
        check("latency", last_coin_cyc - start, D + 3);
        check("clean5_pulses", coins_seen - c0, 1);
        check("clean5_code", last_coin_val, COIN_5);
        hold(2'b00, 1'b1, 10);

        // Bouncing 10-rupee coin.
        bounce = '{2'b10, 2'b00, 2'b10, 2'b10, 2'b00};
        c0 = coins_seen;
        k0 = m_count;
        for (int i = 0; i < 5; i++) step(bounce[i], 1'b1);
        hold(2'b10, 1'b1, 12);
        hold(2'b00, 1'b1, 10);
        check("bounce10_pulses", coins_seen - c0, 1);
        check("bounce10_code", last_coin_val, COIN_10);
        check("bounce10_count", coin_count, k0 + 1);

        // Both slots at once.
        c0 = coins_seen;
        r0 = rejects_seen;
        hold(2'b11, 1'b1, 10);
        hold(2'b00, 1'b1, 10);
        check("jam_rejects", rejects_seen - r0, 1);
        check("jam_coins", coins_seen - c0, 0);

        // Acceptance disabled.
        c0 = coins_seen;
        r0 = rejects_seen;
        hold(2'b01, 1'b0, 12);
        hold(2'b00, 1'b0, 10);
        check("disabled_rejects", rejects_seen - r0, 1);
        check("disabled_coins", coins_seen - c0, 0);

        // Asynchronous reset two cycles into debounce.
        hold(2'b01, 1'b1, 5);
        @(negedge clk);
        sense_5 = 1'b0;
        #2 rst = 1'b0;
        #1;
        check("arst_coin", coin, 0);
        check("arst_reject", coin_reject, 0);
        check("arst_busy", busy, 0);
        check("arst_count", coin_count, 0);
        model_reset();
        hold(2'b00, 1'b1, 3);
        rst = 1'b1;
        c0 = coins_seen;
        r0 = rejects_seen;
        hold(2'b00, 1'b1, 12);
        check("arst_no_pulse", (coins_seen - c0) + (rejects_seen - r0), 0);
        hold(2'b01, 1'b1, 12);
        hold(2'b00, 1'b1, 10);
        check("arst_next_coin", coins_seen - c0, 1);
        check("arst_next_count", coin_count, 1);

        // Random segments: clean holds, jams, bounce noise, random enable.
        for (int i = 0; i < 200; i++) begin
            int n, g, kind;
            logic en;
            logic [1:0] code;
            n    = $urandom_range(1, 10);
            g    = $urandom_range(0, 7);
            kind = $urandom_range(0, 4);
            en   = ($urandom_range(0, 3) != 0);
            code = (kind == 0) ? 2'b01 : (kind == 1) ? 2'b10 : (kind == 2) ? 2'b11 : 2'b01;
            for (int j = 0; j < n; j++) begin
                if (kind == 4) step(2'($urandom_range(0, 3)), en);
                else step(code, en);
            end
            hold(2'b00, en, g);
        end
        hold(2'b00, 1'b1, 10);

        // Saturation at 255.
        while (m_count < 255) begin
            hold(2'b01, 1'b1, 8);
            hold(2'b00, 1'b1, 8);
        end
        c0 = coins_seen;
        hold(2'b01, 1'b1, 8);
        hold(2'b00, 1'b1, 8);
        check("sat_pulse", coins_seen - c0, 1);
        check("sat_code", last_coin_val, COIN_5);
        check("sat_count", coin_count, 255);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
